// File: rtl/serial_tx8.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional even parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module serial_tx8 #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [BIT_W-1:0]  bit_idx, bit_idx_n;
   logic [DATA_W-1:0] word, word_n;
   logic              par, par_n;
   logic              tx_n, ready_n, done_n;
   logic              cnt_last;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         word    <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         word    <= word_n;
         par     <= par_n;
         tx      <= tx_n;
         ready   <= ready_n;
         done    <= done_n;
      end
   end

   assign cnt_last = (cnt == CNT_LAST);

   // Next state; tx/ready/done are computed one edge ahead so they come out registered
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      word_n    = word;
      par_n     = par;
      tx_n      = tx;
      ready_n   = ready;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               word_n  = in;
               par_n   = ^in;
               state_n = START;
               cnt_n   = '0;
               tx_n    = 1'b0;
               ready_n = 1'b0;
            end
         end
         START: begin
            if (cnt_last) begin
               state_n   = DATA;
               cnt_n     = '0;
               bit_idx_n = '0;
               tx_n      = word[0];
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_last) begin
               cnt_n = '0;
               if (bit_idx == BIT_LAST) begin
                  if (PARITY_EN != 0) begin
                     state_n = PARITY;
                     tx_n    = par;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_idx_n = bit_idx + BIT_W'(1);
                  tx_n      = word[bit_idx + BIT_W'(1)];
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_last) begin
               state_n = STOP;
               cnt_n   = '0;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_last) begin
               state_n = IDLE;
               cnt_n   = '0;
               tx_n    = 1'b1;
               ready_n = 1'b1;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            tx_n    = 1'b1;
            ready_n = 1'b1;
         end
      endcase
   end

endmodule
